// File: rtl/t_codec_pkg.sv
// Shared definitions for the toggle-line codec (decoder now, encoder later).
package t_codec_pkg;

  typedef enum logic {HUNT, DATA} state_t;

  localparam int unsigned   T_WIDTH = 8;
  localparam logic [7:0]    T_SYNC  = 8'hA5;

endpackage

// File: rtl/t_toggle_decoder_if.sv
// Line-side inputs and word-side outputs of the toggle decoder.
interface t_toggle_decoder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             t;
  logic             e;
  logic [WIDTH-1:0] q;
  logic             valid;
  logic             locked;
  logic             frame_done;

  modport master (output t, e, input q, valid, locked, frame_done);
  modport slave  (input t, e, output q, valid, locked, frame_done);
endinterface

// File: rtl/t_bit_decode.sv
// Recovers one bit per strobe from the toggle line: b = t ^ previous sampled line.
module t_bit_decode (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic e,
  output logic b,
  output logic b_stb
);
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst)    r_prev <= 1'b0;
    else if (e) r_prev <= t;
  end

  assign b     = t ^ r_prev;
  assign b_stb = e;
endmodule

// File: rtl/t_toggle_decoder.sv
// Toggle-line receiver: hunts for SYNC, then deserialises FRAME_WORDS words MSB-first.
module t_toggle_decoder
  import t_codec_pkg::*;
#(
  parameter int unsigned      WIDTH       = T_WIDTH,
  parameter logic [WIDTH-1:0] SYNC        = T_SYNC,
  parameter int unsigned      FRAME_WORDS = 4
) (
  input  logic clk,
  input  logic rst,
  t_toggle_decoder_if.slave bus
);
  localparam int unsigned BW = $clog2(WIDTH + 1);

  logic             w_b;
  logic             w_stb;
  logic [WIDTH-1:0] w_shift;
  logic [BW-1:0]    w_bit_next;
  logic [7:0]       w_word_next;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bitcnt;
  logic [7:0]       r_wordcnt;
  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic             r_locked;
  logic             r_frame_done;

  t_bit_decode u_bit_decode (
    .clk   (clk),
    .rst   (rst),
    .t     (bus.t),
    .e     (bus.e),
    .b     (w_b),
    .b_stb (w_stb)
  );

  assign w_shift     = {r_shift[WIDTH-2:0], w_b};
  assign w_bit_next  = r_bitcnt + BW'(1);
  assign w_word_next = r_wordcnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= HUNT;
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_wordcnt    <= '0;
      r_q          <= '0;
      r_valid      <= 1'b0;
      r_locked     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_stb) begin
        r_shift <= w_shift;
        case (r_state)
          HUNT: begin
            // Compare the post-shift value so lock happens on the completing strobe.
            if (w_shift == SYNC) begin
              r_state   <= DATA;
              r_locked  <= 1'b1;
              r_bitcnt  <= '0;
              r_wordcnt <= '0;
            end
          end
          DATA: begin
            if (w_bit_next == BW'(WIDTH)) begin
              r_q      <= w_shift;
              r_valid  <= 1'b1;
              r_bitcnt <= '0;
              if (w_word_next == 8'(FRAME_WORDS)) begin
                r_frame_done <= 1'b1;
                r_state      <= HUNT;
                r_locked     <= 1'b0;
                r_shift      <= '0;
                r_wordcnt    <= '0;
              end else begin
                r_wordcnt <= w_word_next;
              end
            end else begin
              r_bitcnt <= w_bit_next;
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign bus.q          = r_q;
  assign bus.valid      = r_valid;
  assign bus.locked     = r_locked;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_t_toggle_decoder.sv
// Directed self-checking bench for t_toggle_decoder.
module tb_t_toggle_decoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic line = 1'b0;

  int checks   = 0;
  int failures = 0;
  int nvalid   = 0;
  int nfd      = 0;
  logic [7:0] qlast = '0;

  t_toggle_decoder_if #(.WIDTH(8)) bus ();

  t_toggle_decoder #(.WIDTH(8), .SYNC(8'hA5), .FRAME_WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock and record any valid / frame_done pulse seen just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.valid) begin
      nvalid++;
      qlast = bus.q;
    end
    if (bus.frame_done) nfd++;
  endtask

  task automatic send_bit(input logic b, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      bus.e = 1'b0;
      bus.t = 1'($urandom);
      tick();
    end
    line  = line ^ b;
    bus.t = line;
    bus.e = 1'b1;
    tick();
    bus.e = 1'b0;
    bus.t = line;
  endtask

  task automatic send_word(input logic [7:0] w, input int gaps);
    nvalid = 0;
    nfd    = 0;
    for (int i = 7; i >= 0; i--) send_bit(w[i], gaps);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    bus.t = 1'b1;
    bus.e = 1'b1;
    tick();
    tick();
    rst   = 1'b0;
    bus.e = 1'b0;
    bus.t = 1'b0;
    line  = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    bus.t = 1'b1;
    bus.e = 1'b1;
    tick();
    tick();
    checks++; if (bus.q !== 8'h00) begin failures++; $display("FAIL reset_q actual=%h expected=00", bus.q); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b expected=0", bus.valid); end
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL reset_locked actual=%b expected=0", bus.locked); end
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done actual=%b expected=0", bus.frame_done); end
    rst   = 1'b0;
    bus.e = 1'b0;
    bus.t = 1'b0;
    line  = 1'b0;
  endtask

  task automatic test_sync();
    logic [7:0] lv;
    lv = 8'b11000110;
    nvalid = 0;
    for (int i = 7; i >= 0; i--) begin
      bus.t = lv[i];
      bus.e = 1'b1;
      tick();
      if (i == 1) begin
        checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL sync_early_lock actual=%b expected=0", bus.locked); end
      end
    end
    bus.e = 1'b0;
    line  = 1'b0;
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL sync_locked actual=%b expected=1", bus.locked); end
    checks++; if (nvalid !== 0) begin failures++; $display("FAIL sync_no_valid actual=%0d expected=0", nvalid); end
  endtask

  task automatic test_word();
    send_word(8'h3C, 0);
    checks++; if (nvalid !== 1) begin failures++; $display("FAIL word_valid_count actual=%0d expected=1", nvalid); end
    checks++; if (qlast !== 8'h3C) begin failures++; $display("FAIL word_q actual=%h expected=3C", qlast); end
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL word_locked actual=%b expected=1", bus.locked); end
    tick();
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL word_valid_one_cycle actual=%b expected=0", bus.valid); end
    checks++; if (bus.q !== 8'h3C) begin failures++; $display("FAIL word_q_hold actual=%h expected=3C", bus.q); end
  endtask

  task automatic run_frame(input int gaps, input string tag);
    logic [7:0] w;
    send_word(8'hA5, gaps);
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL %s_lock actual=%b expected=1", tag, bus.locked); end
    for (int k = 1; k <= 4; k++) begin
      w = 8'(k);
      send_word(w, gaps);
      checks++; if (nvalid !== 1) begin failures++; $display("FAIL %s_w%0d_valid actual=%0d expected=1", tag, k, nvalid); end
      checks++; if (qlast !== w) begin failures++; $display("FAIL %s_w%0d_q actual=%h expected=%h", tag, k, qlast, w); end
      checks++; if (nfd !== ((k == 4) ? 1 : 0)) begin failures++; $display("FAIL %s_w%0d_fd actual=%0d expected=%0d", tag, k, nfd, (k == 4) ? 1 : 0); end
      checks++; if (bus.locked !== (k != 4)) begin failures++; $display("FAIL %s_w%0d_locked actual=%b expected=%b", tag, k, bus.locked, k != 4); end
    end
    tick();
    checks++; if (bus.valid !== 1'b0 || bus.frame_done !== 1'b0) begin failures++; $display("FAIL %s_pulse_end actual=%b%b expected=00", tag, bus.valid, bus.frame_done); end
    checks++; if (bus.q !== 8'h04 || bus.locked !== 1'b0) begin failures++; $display("FAIL %s_idle actual=q%h/l%b expected=q04/l0", tag, bus.q, bus.locked); end
  endtask

  task automatic test_full_frame();
    do_reset();
    run_frame(0, "frame");
  endtask

  task automatic test_strobe_gaps();
    do_reset();
    run_frame(3, "gaps");
  endtask

  task automatic test_reset_mid_frame();
    int total;
    logic [7:0] w;
    do_reset();
    send_word(8'hA5, 0);
    nvalid = 0;
    for (int i = 7; i >= 3; i--) send_bit(1'b1, 0);
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    line = 1'b0;
    bus.t = 1'b0;
    checks++; if (nvalid !== 0 || bus.locked !== 1'b0 || bus.q !== 8'h00) begin failures++; $display("FAIL abort actual=v%0d/l%b/q%h expected=v0/l0/q00", nvalid, bus.locked, bus.q); end
    total = 0;
    for (int k = 1; k <= 4; k++) begin
      w = 8'(k * 17);
      send_word(w, 1);
      total += nvalid;
    end
    checks++; if (total !== 0 || bus.locked !== 1'b0) begin failures++; $display("FAIL nosync_frame actual=v%0d/l%b expected=v0/l0", total, bus.locked); end
    run_frame(0, "resync");
  endtask

  initial begin
    bus.t = 1'b0;
    bus.e = 1'b0;
    test_reset();
    test_sync();
    test_word();
    test_full_frame();
    test_strobe_gaps();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
